tinker_mem_responder: RTL and testbench

//  Memory-side responder for the tinker core's load/store/fetch requests. It

---
 rtl/tinker_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_tinker_mem_responder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinker_mem_responder.sv
// ============================================================================
// tinker_mem_responder
// ----------------------------------------------------------------------------
// Memory-side responder for the tinker core's load, store and fetch requests.
// It owns a byte-addressed, little-endian array of 2**ADDR_W bytes. The
// default of 19 bits covers the 0x80000-byte address space, with the stack
// top at 0x80000. The responder services one request at a time. Requests
// arrive on a valid/ready channel, and each completion is reported by a
// single-cycle response pulse that arrives after a fixed latency.
//
// Optional feature (compile-time macro):
//   MEM_BOUNDS_CHK_EN - when defined, a request whose address has any bit
//                       above ADDR_W-1 set, or whose last byte lies at or
//                       beyond 2**ADDR_W, still takes the normal latency.
//                       It then completes with rsp_err=1 and rsp_rdata=0,
//                       and writes no bytes. When undefined, rsp_err is tied
//                       to 0 and addresses wrap modulo 2**ADDR_W.
//
// Parameters:
//   ADDR_W   byte-address bits decoded; array depth is 2**ADDR_W bytes
//   LATENCY  1..15, accept edge to response-pulse edge distance
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-low reset (0 = in reset)
//   req_valid  in   1   request present
//   req_ready  out  1   responder idle, can accept a request
//   req_write  in   1   1 = 64-bit store, 0 = read; ignored when req_fetch=1
//   req_fetch  in   1   1 = 32-bit instruction fetch (read only)
//   req_addr   in   64  byte address of the lowest byte
//   req_wdata  in   64  store data; byte 0 goes to req_addr
//   rsp_valid  out  1   one-cycle pulse: the request has completed
//   rsp_rdata  out  64  read data, valid only while rsp_valid=1
//   rsp_err    out  1   out-of-range flag, valid with rsp_valid
//
// Handshake:
//   A request transfers on a rising edge where req_valid=1 and req_ready=1.
//   req_ready is a registered output and is 1 only in IDLE. While
//   req_ready=0, all req_* inputs are ignored. Only one request is ever
//   outstanding. The response has no back-pressure: rsp_valid is a
//   single-cycle pulse, and the requester must sample it on the pulse.
//
// Timing (accept on edge N):
//   - The state is WAIT for LATENCY-1 cycles. RESP is entered on edge
//     N+LATENCY-1, and the array access is performed on that edge.
//   - rsp_valid is high in the cycle after edge N+LATENCY. In that same
//     cycle the FSM is already back in IDLE with req_ready=1.
//   - With req_valid held high, requests are therefore accepted every
//     LATENCY+1 cycles. req_ready is 0 throughout WAIT and RESP.
//
// Reset:
//   - Asserting reset in WAIT or RESP drops the pending request. A store
//     that has not yet reached its RESP entry edge never writes. rsp_valid
//     is cleared at once.
//   - The byte array is not reset, so its contents persist across reset.
// ============================================================================
module tinker_mem_responder #(
    parameter int ADDR_W  = 19,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_fetch,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         MEM_BYTES = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------
    state_t      state;
    logic [3:0]  cnt;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic        write_q;
    logic        fetch_q;

    logic [7:0]  mem [0:MEM_BYTES-1];

    // ------------------------------------------------------------------
    // Access view: in IDLE this is the incoming request, which matters
    // when LATENCY=1 and the access happens on the accept edge itself.
    // In every other state it is the latched request.
    // ------------------------------------------------------------------
    logic [63:0]       acc_addr;
    logic [63:0]       acc_wdata;
    logic              acc_write;
    logic              acc_fetch;
    logic              acc_err;
    logic              accept;
    logic              enter_resp;
    logic              commit_we;
    logic [ADDR_W-1:0] byte_idx [0:7];
    logic [63:0]       rd_word;
    logic [63:0]       rsp_word;

    always_comb begin
        if (state == ST_IDLE) begin
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_write = req_write;
            acc_fetch = req_fetch;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_write = write_q;
            acc_fetch = fetch_q;
        end
    end

    // ------------------------------------------------------------------
    // Accept and RESP-entry decisions.
    // An unknown req_valid falls into the "no request" path, because an
    // if-condition that is X is not taken.
    // ------------------------------------------------------------------
    always_comb begin
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (CNT_LOAD == 4'd0) begin
                        enter_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // The counter reaches 0 on this edge.
                if (cnt == 4'd1) begin
                    enter_resp = 1'b1;
                end
            end
            default: begin
                accept     = 1'b0;
                enter_resp = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte lanes. The index is truncated to ADDR_W bits, so a multi-byte
    // access that runs past the top of the array wraps to address 0.
    // ------------------------------------------------------------------
    always_comb begin
        rd_word = 64'd0;
        for (int i = 0; i < 8; i++) begin
            byte_idx[i]       = acc_addr[ADDR_W-1:0] + ADDR_W'(i);
            rd_word[8*i +: 8] = mem[byte_idx[i]];
        end
    end

`ifdef MEM_BOUNDS_CHK_EN
    // The end address is computed one bit wider than the array index, so
    // a carry out of the array range lands in end_addr[ADDR_W].
    logic [ADDR_W:0] end_addr;

    always_comb begin
        end_addr = {1'b0, acc_addr[ADDR_W-1:0]}
                 + (acc_fetch ? (ADDR_W+1)'(3) : (ADDR_W+1)'(7));
        acc_err  = (|acc_addr[63:ADDR_W]) | end_addr[ADDR_W];
    end
`else
    // Without range checking, the address bits above ADDR_W-1 play no part.
    logic unused_hi_addr;

    assign acc_err        = 1'b0;
    assign unused_hi_addr = |acc_addr[63:ADDR_W];
`endif

    // Stores and errored requests answer with zero data. A fetch returns
    // only its four bytes.
    always_comb begin
        rsp_word = 64'd0;
        if (!acc_err && !(acc_write && !acc_fetch)) begin
            if (acc_fetch) begin
                rsp_word = {32'd0, rd_word[31:0]};
            end else begin
                rsp_word = rd_word;
            end
        end
    end

    // The store commits on the RESP entry edge. The reset term keeps an
    // edge that arrives while reset is held from writing a request that
    // the FSM is dropping.
    assign commit_we = enter_resp & reset & acc_write & ~acc_fetch & ~acc_err;

    // ------------------------------------------------------------------
    // Byte array. It has no reset, so its contents survive reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (commit_we) begin
            for (int i = 0; i < 8; i++) begin
                mem[byte_idx[i]] <= acc_wdata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Request FSM with registered outputs. The response is registered on
    // the RESP -> IDLE edge, so the pulse appears in the first IDLE cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            addr_q    <= 64'd0;
            wdata_q   <= 64'd0;
            write_q   <= 1'b0;
            fetch_q   <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 64'd0;
`ifdef MEM_BOUNDS_CHK_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 64'd0;
`ifdef MEM_BOUNDS_CHK_EN
                    rsp_err   <= 1'b0;
`endif
                    if (accept) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        write_q   <= req_write;
                        fetch_q   <= req_fetch;
                        cnt       <= CNT_LOAD;
                        req_ready <= 1'b0;
                        state     <= enter_resp ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (enter_resp) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // The array access already happened on the entry edge.
                    // Here the completion is only reported.
                    state     <= ST_IDLE;
                    cnt       <= 4'd0;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rsp_word;
`ifdef MEM_BOUNDS_CHK_EN
                    rsp_err   <= acc_err;
`endif
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= 4'd0;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 64'd0;
                end
            endcase
        end
    end

`ifndef MEM_BOUNDS_CHK_EN
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_tinker_mem_responder.sv
// ============================================================================
// tb_tinker_mem_responder
// ----------------------------------------------------------------------------
// Self-checking bench for tinker_mem_responder (ADDR_W=19, LATENCY=2).
//
// The driver issues requests and computes each expected response from a
// byte-array reference model. It pushes that response, together with the
// cycle in which the pulse is due, into the scoreboard queues. A monitor
// running on the falling edge pops and compares every rsp_valid pulse. It
// also checks that req_ready stays low while a request is outstanding.
//
// Pulse timing: a request accepted on rising edge N must pulse rsp_valid in
// the cycle after edge N+LAT, and the responder is idle again in that cycle.
//
// Build the bench with +define+MEM_BOUNDS_CHK_EN to check that variant of
// the design.
// ============================================================================
module tb_tinker_mem_responder;

    localparam int ADDR_W   = 19;
    localparam int LAT      = 2;
    localparam int MEM_SIZE = 1 << ADDR_W;

    // ------------------------------------------------------------------
    // Clock, reset, DUT
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_fetch = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    // Counts rising edges. After edge N, cyc holds the value N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    tinker_mem_responder #(
        .ADDR_W  (ADDR_W),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_fetch (req_fetch),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always @(posedge clk) begin
        if (reset && req_ready) begin
            assert (!$isunknown(req_valid))
                else $error("req_valid is unknown while the responder is idle");
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard state and counters
    // ------------------------------------------------------------------
    logic [63:0] exp_q[$];
    logic        exp_err_q[$];
    int          exp_cyc_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [7:0]  ref_mem [MEM_SIZE];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: plain byte array, little-endian, wrapping modulo
    // the array size.
    // ------------------------------------------------------------------
    function automatic int idx(input logic [63:0] a, input int i);
        return int'((a + 64'(i)) % 64'(MEM_SIZE));
    endfunction

    task automatic model(input logic w, input logic f, input logic [63:0] a,
                         input logic [63:0] d, input bit upd,
                         output logic [63:0] rd, output logic er);
        int n;
        rd = 64'd0;
        er = 1'b0;
        n  = f ? 4 : 8;
`ifdef MEM_BOUNDS_CHK_EN
        if ((a >> ADDR_W) != 64'd0 || (a + 64'(n - 1)) >= 64'(MEM_SIZE)) er = 1'b1;
`endif
        if (!er) begin
            if (w && !f) begin
                if (upd) begin
                    for (int i = 0; i < 8; i++) ref_mem[idx(a, i)] = d[8*i +: 8];
                end
            end else begin
                for (int i = 0; i < n; i++) rd[8*i +: 8] = ref_mem[idx(a, i)];
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Driver.
    //   push: queue an expected response.
    //   upd:  apply the access to the model.
    //   hold: leave req_valid high after the accept edge.
    // ------------------------------------------------------------------
    task automatic issue(input logic w, input logic f, input logic [63:0] a,
                         input logic [63:0] d, input bit push, input bit upd,
                         input bit hold, output int acc_cyc);
        int          g;
        logic [63:0] rd;
        logic        er;
        g = 0;
        acc_cyc = -1;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_fetch = f;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: req_ready=%0b after %0d cycles, expected 1", req_ready, g);
            req_valid = 1'b0;
            return;
        end
        model(w, f, a, d, upd, rd, er);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (push) begin
            exp_q.push_back(rd);
            exp_err_q.push_back(er);
            exp_cyc_q.push_back(cyc + LAT);
        end
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
            exp_err_q.delete();
            exp_cyc_q.delete();
        end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [63:0] mon_d;
    logic        mon_e;
    int          mon_c;

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected @cycle %0d: rsp_valid=1, expected 0", cyc);
            end else begin
                mon_d = exp_q.pop_front();
                mon_e = exp_err_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("rsp_rdata", rsp_rdata, mon_d);
                check("rsp_err", 64'(rsp_err), 64'(mon_e));
                check("rsp_cycle", 64'(cyc), 64'(mon_c));
                check("ready_at_pulse", 64'(req_ready), 64'd1);
            end
        end else if (exp_cyc_q.size() != 0) begin
            check("ready_busy", 64'(req_ready), 64'd0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int          ac;
        int          acc[4];
        logic        w;
        logic        f;
        logic [63:0] a;
        int          op;

        // 1. Reset held low for 3 cycles, then released.
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", 64'(req_ready), 64'd1);
            check("rst_valid", 64'(rsp_valid), 64'd0);
            check("rst_rdata", rsp_rdata, 64'd0);
            check("rst_err", 64'(rsp_err), 64'd0);
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_ready", 64'(req_ready), 64'd1);
            check("post_rst_valid", 64'(rsp_valid), 64'd0);
            check("post_rst_rdata", rsp_rdata, 64'd0);
        end

        // 2. Store followed by a load of the same address.
        issue(1'b1, 1'b0, 64'h2000, 64'h1122334455667788, 1, 1, 0, ac);
        drain();
        issue(1'b0, 1'b0, 64'h2000, 64'h0, 1, 1, 0, ac);
        drain();

        // 3. Misaligned fetch. Then a store with req_fetch=1, which must act
        //    as a fetch and change no bytes.
        issue(1'b0, 1'b1, 64'h2002, 64'h0, 1, 1, 0, ac);
        issue(1'b1, 1'b1, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, ac);
        issue(1'b0, 1'b0, 64'h2000, 64'h0, 1, 1, 0, ac);
        drain();

        // 4. Store across the top of the array.
        issue(1'b1, 1'b0, 64'h7FFF8, 64'h0102030405060708, 1, 1, 0, ac);
        issue(1'b1, 1'b0, 64'h0,     64'h1112131415161718, 1, 1, 0, ac);
        issue(1'b1, 1'b0, 64'h7FFFC, 64'hAABBCCDDEEFF0011, 1, 1, 0, ac);
        issue(1'b0, 1'b0, 64'h7FFF8, 64'h0, 1, 1, 0, ac);
        issue(1'b0, 1'b0, 64'h0,     64'h0, 1, 1, 0, ac);
        issue(1'b0, 1'b1, 64'h7FFFE, 64'h0, 1, 1, 0, ac);
        drain();

        // 5a. Reset while the store is in WAIT: the store is dropped.
        issue(1'b1, 1'b0, 64'h3000, 64'h0BADF00D_CAFEF00D, 1, 1, 0, ac);
        drain();
        issue(1'b1, 1'b0, 64'h3000, 64'hDEADBEEF_00000000, 0, 0, 0, ac);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("wait_rst_valid", 64'(rsp_valid), 64'd0);
            check("wait_rst_ready", 64'(req_ready), 64'd1);
        end
        reset = 1'b1;
        repeat (LAT + 2) begin
            @(negedge clk);
            check("wait_rst_no_pulse", 64'(rsp_valid), 64'd0);
        end
        issue(1'b0, 1'b0, 64'h3000, 64'h0, 1, 1, 0, ac);
        drain();

        // 5b. Reset after the RESP entry edge: the store has committed, but
        //     no pulse follows.
        issue(1'b1, 1'b0, 64'h3100, 64'h1111_2222_3333_4444, 1, 1, 0, ac);
        drain();
        issue(1'b1, 1'b0, 64'h3100, 64'h5555_6666_7777_8888, 0, 1, 0, ac);
        repeat (LAT - 1) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("resp_rst_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (LAT + 2) begin
            @(negedge clk);
            check("resp_rst_no_pulse", 64'(rsp_valid), 64'd0);
        end
        issue(1'b0, 1'b0, 64'h3100, 64'h0, 1, 1, 0, ac);
        drain();

        // Fill the 0x1000 window that later tests read from.
        for (int k = 0; k < 9; k++) begin
            issue(1'b1, 1'b0, 64'h1000 + 64'(8 * k), {$urandom, $urandom}, 1, 1, 0, ac);
        end
        drain();

        // 6. req_valid held high for 4 loads: accepts LAT+1 cycles apart.
        for (int k = 0; k < 4; k++) begin
            issue(1'b0, 1'b0, 64'h1000 + 64'(8 * k + k), 64'h0, 1, 1, (k != 3), acc[k]);
        end
        drain();
        for (int k = 1; k < 4; k++) begin
            check("b2b_spacing", 64'(acc[k] - acc[k-1]), 64'(LAT + 1));
        end

        // Random traffic over the initialised windows. Some requests carry
        // junk in the high address bits.
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 3);
            w  = (op == 1) || (op == 3);
            f  = (op == 2) || (op == 3);
            if ($urandom_range(0, 3) == 0) a = 64'h7FFF8 + 64'($urandom_range(0, 7));
            else                           a = 64'h1000 + 64'($urandom_range(0, 56));
            if ($urandom_range(0, 4) == 0) a[63:32] = $urandom | 32'h1;
            issue(w, f, a, {$urandom, $urandom}, 1, 1, 0, ac);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within its time budget");
        $fatal(1, "watchdog expired");
    end

endmodule
